exec_unit: RTL and testbench

Parametrised execute-stage unit for the five-stage pipeline. It replaces the fixed 16-bit ALU. Operands arrive from decode/register-read over a valid/ready handshake, and results leave through a registered output stage toward memory. It keeps an architectural C/N/Z flag register, adds logic, subtract and shift operations, and supports an optional iterative multiplier that stalls the stage without dropping operands.

---
 rtl/exec_pkg.sv | 39 +++
 rtl/exec_mul_seq.sv | 56 +++++
 rtl/exec_unit.sv | 164 ++++++++++++++++
 tb/tb_exec_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, FSM encoding, flag record and flag-write lookup
// for the execute stage. Build option: EXEC_MUL_EN enables the MUL opcode.
package exec_pkg;

    localparam logic [3:0] OP_LDD = 4'b0001;
    localparam logic [3:0] OP_STD = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_NOP = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic carry;
        logic neg;
        logic zero;
    } flags_t;

    // Loads, stores, NOP and undefined opcodes leave the flags alone.
    function automatic logic writes_flags(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_SHL, OP_SHR: return 1'b1;
`ifdef EXEC_MUL_EN
            OP_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: iterative shift-add multiplier, one partial product per clk.
// done_o flags the cycle of the last step; product_o is valid in that cycle.
module exec_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);

    logic               active_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // Accumulate the current multiplicand when the low multiplier bit is set.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign done_o    = active_q && (count_q == CW'(WIDTH - 1));
    assign product_o = acc_d;

    // Load operands on start, then step once per clk until the last bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (active_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage with valid/ready input, registered result stage
// and C/N/Z flag register. Build option: EXEC_MUL_EN adds the iterative MUL.
//
//   state   | meaning
//   IDLE    | accepting operations; single-cycle ops complete here
//   BUSY    | multiplier stepping; input stalled (EXEC_MUL_EN only)
module exec_unit
    import exec_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             zero_o,
    output logic             illegal_o
);
    logic [WIDTH-1:0] result_q;
    logic             out_valid_q;
    logic             illegal_q;
    flags_t           flags_q;

    logic             room;
    logic             accept;
    logic             single_write;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_illegal;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [SHW-1:0]   amt;

    assign room = !out_valid_q || out_ready_i;

`ifdef EXEC_MUL_EN
    state_t             state_q;
    logic               alu_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready_o   = rst && (state_q == ST_IDLE) && room;
    assign single_write = accept && !alu_mul;

    exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept && alu_mul),
        .a_i       (a_i),
        .b_i       (b_i),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign in_ready_o   = rst && room;
    assign single_write = accept;
`endif

    assign accept = in_valid_i && in_ready_o;

    // Single-cycle datapath; the shift words carry one extra bit to catch
    // the last bit shifted out (zero when the amount is zero).
    always_comb begin
        amt         = a_i[SHW-1:0];
        sum_w       = {1'b0, a_i} + {1'b0, b_i};
        shl_w       = {1'b0, b_i} << amt;
        shr_w       = {b_i, 1'b0} >> amt;
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
`ifdef EXEC_MUL_EN
        alu_mul     = 1'b0;
`endif
        case (func_i)
            OP_LDD, OP_STD: alu_res = a_i;
            OP_ADD: {alu_carry, alu_res} = sum_w;
            OP_NOT: alu_res = ~b_i;
            OP_NOP: alu_res = '0;
            OP_SUB: begin
                alu_res   = a_i - b_i;
                alu_carry = (a_i < b_i);
            end
            OP_AND: alu_res = a_i & b_i;
            OP_OR:  alu_res = a_i | b_i;
            OP_SHL: {alu_carry, alu_res} = shl_w;
            OP_SHR: begin
                alu_res   = shr_w[WIDTH:1];
                alu_carry = shr_w[0];
            end
`ifdef EXEC_MUL_EN
            OP_MUL: alu_mul = 1'b1;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    // Result/flag register, output handshake and IDLE/BUSY sequencing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            flags_q     <= '0;
`ifdef EXEC_MUL_EN
            state_q     <= ST_IDLE;
`endif
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (single_write) begin
                result_q    <= alu_res;
                out_valid_q <= 1'b1;
                illegal_q   <= alu_illegal;
                if (writes_flags(func_i)) begin
                    flags_q <= '{carry: alu_carry,
                                 neg:   alu_res[WIDTH-1],
                                 zero:  (alu_res == '0)};
                end
            end
`ifdef EXEC_MUL_EN
            case (state_q)
                ST_IDLE: begin
                    if (accept && alu_mul) begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Output stage was free or draining at entry, so it is
                    // guaranteed empty by the time the last step lands.
                    if (mul_done) begin
                        result_q    <= mul_prod[WIDTH-1:0];
                        out_valid_q <= 1'b1;
                        illegal_q   <= 1'b0;
                        flags_q     <= '{carry: (|mul_prod[2*WIDTH-1:WIDTH]),
                                         neg:   mul_prod[WIDTH-1],
                                         zero:  (mul_prod[WIDTH-1:0] == '0)};
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign carry_o     = flags_q.carry;
    assign neg_o       = flags_q.neg;
    assign zero_o      = flags_q.zero;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vector table, hand sequences for back-pressure and
// reset-during-multiply, then random ops against an arithmetic model.
module tb_exec_unit;
    localparam int W = 16;
    localparam longint M = 64'hFFFF;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    func;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry, neg, zero, illegal;

    int total = 0;
    int bad   = 0;
    bit m_c = 0, m_n = 0, m_z = 0;

    exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .func_i      (func),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .carry_o     (carry),
        .neg_o       (neg),
        .zero_o      (zero),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         c;
        logic         n;
        logic         z;
        logic         il;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the opcode rules, using plain integer maths.
    task automatic model_op(input logic [3:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            output longint r, output bit il, output int lat);
        longint av, bv, p, n;
        bit wf, c;
        av = longint'(aa); bv = longint'(bb); n = av % 16;
        wf = 1; c = 0; il = 0; r = 0; lat = 0;
        case (f)
            4'd1, 4'd2: begin r = av; wf = 0; end
            4'd3: begin r = (av + bv) & M; c = (av + bv) > M; end
            4'd4: r = (~bv) & M;
            4'd5: begin r = 0; wf = 0; end
            4'd6: begin r = (av - bv) & M; c = av < bv; end
            4'd7: r = av & bv;
            4'd8: r = av | bv;
            4'd9: begin r = (bv << n) & M; c = (n != 0) && (((bv >> (16 - n)) & 1) == 1); end
            4'd10: begin r = bv >> n; c = (n != 0) && (((bv >> (n - 1)) & 1) == 1); end
            4'd11: begin
                if (MUL_EN) begin
                    p = av * bv; r = p & M; c = (p >> 16) != 0; lat = W;
                end else begin
                    il = 1; wf = 0;
                end
            end
            default: begin il = 1; wf = 0; end
        endcase
        if (wf) begin
            m_c = c; m_n = ((r >> 15) & 1) == 1; m_z = (r == 0);
        end
    endtask

    // Present one op, wait for acceptance and then for the result.
    task automatic run_op(input logic [3:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          output int lat, output int rdy_hi);
        int n;
        func = f; a = aa; b = bb; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; rdy_hi = 0;
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1; lat++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic c, input logic n,
                             input logic z, input logic il);
        check({tag, "_result"}, result, r);
        check({tag, "_carry"}, carry, c);
        check({tag, "_neg"}, neg, n);
        check({tag, "_zero"}, zero, z);
        check({tag, "_illegal"}, illegal, il);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rh, mlat;
        longint mr;
        bit mil;
        logic [3:0] rf;
        logic [W-1:0] ra, rb;

        tbl[0]  = '{4'h3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'h6, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'h1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'h9, 16'h0001, 16'h8001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'hF, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'hA, 16'h0004, 16'h00F8, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'h7, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'h8, 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'h4, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'h5, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{4'h9, 16'h0000, 16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'h2, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{4'h3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{4'hA, 16'h000F, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'h6, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        if (MUL_EN) tbl[15] = '{4'hB, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        else        tbl[15] = '{4'hB, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; func = 4'h0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, lat, rh);
            model_op(tbl[i].f, tbl[i].a, tbl[i].b, mr, mil, mlat);
            check($sformatf("vec%0d_latency", i), lat, mlat);
            check_out($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].n, tbl[i].z, tbl[i].il);
        end

        // Back-pressure: result held, input stalled, then consume+accept together.
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op(4'h3, 16'h0001, 16'h0002, lat, rh);
        model_op(4'h3, 16'h0001, 16'h0002, mr, mil, mlat);
        func = 4'h8; a = 16'h0F00; b = 16'h00F0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_result", result, 16'h0003);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_op(4'h8, 16'h0F00, 16'h00F0, mr, mil, mlat);
        check("bp_nobubble_valid", out_valid, 1);
        check_out("bp_nobubble", 16'h0FF0, m_c, m_n, m_z, 1'b0);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);
        check("bp_flags_stable_c", carry, m_c);
        check("bp_flags_stable_z", zero, m_z);

        // Multiply with full-width overflow.
        run_op(4'hB, 16'h0100, 16'h0100, lat, rh);
        model_op(4'hB, 16'h0100, 16'h0100, mr, mil, mlat);
        check("mul_latency", lat, mlat);
        check("mul_ready_low", rh, 0);
        check_out("mul", mr[W-1:0], m_c, m_n, m_z, mil);

        // Reset in the middle of a multiply.
        run_op(4'h3, 16'hFFFF, 16'h0001, lat, rh);
        model_op(4'h3, 16'hFFFF, 16'h0001, mr, mil, mlat);
        func = 4'hB; a = 16'h0003; b = 16'h0007; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check_out("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; m_c = 0; m_n = 0; m_z = 0;
        #1;
        check("midrst_idle_ready", in_ready, 1);
        repeat (W + 2) begin
            @(posedge clk); #1;
            check("midrst_no_stale_result", out_valid, 0);
        end
        run_op(4'h3, 16'h0002, 16'h0003, lat, rh);
        model_op(4'h3, 16'h0002, 16'h0003, mr, mil, mlat);
        check("postrst_add_latency", lat, 0);
        check_out("postrst_add", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random ops against the model.
        for (int i = 0; i < 150; i++) begin
            rf = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 16'hFFFF - ra + 16'($urandom_range(0, 2));
            run_op(rf, ra, rb, lat, rh);
            model_op(rf, ra, rb, mr, mil, mlat);
            check($sformatf("rnd%0d_latency", i), lat, mlat);
            check_out($sformatf("rnd%0d_f%0h", i, rf), mr[W-1:0], m_c, m_n, m_z, mil);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
